oc_qsfp_sideband: RTL and testbench

//  Per-cage QSFP low-speed sideband manager for PortCount cages; replaces raw GPIO bit-banging of the

---
 rtl/oc_qsfp_sideband.sv | 160 ++++++++++++++++
 tb/tb_oc_qsfp_sideband.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/oc_qsfp_sideband.sv
// Per-cage QSFP sideband manager: synchronizes and debounces presence/interrupt pins,
// sequences module reset and init after insertion, and latches interrupts for the CSR layer.
module oc_qsfp_sideband #(
  parameter int PortCount      = 2,
  parameter int DebounceCycles = 65536,
  parameter int ResetCycles    = 1600,
  parameter int InitCycles     = 320000,
  parameter int InsertCountW   = 8
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic [PortCount-1:0]              modPrsL,
  input  logic [PortCount-1:0]              intL,
  output logic [PortCount-1:0]              resetL,
  output logic [PortCount-1:0]              lpMode,
  output logic [PortCount-1:0]              modSelL,
  input  logic [PortCount-1:0]              ctlResetReq,
  input  logic [PortCount-1:0]              ctlLpMode,
  input  logic [PortCount-1:0]              ctlIntEnable,
  input  logic [PortCount-1:0]              ctlIntClear,
  output logic [2*PortCount-1:0]            statState,
  output logic [PortCount-1:0]              statPresent,
  output logic [PortCount-1:0]              intPending,
  output logic [InsertCountW*PortCount-1:0] insertCount,
  output logic                              irq
);

  localparam int TmrMax = (ResetCycles > InitCycles) ? ResetCycles : InitCycles;
  localparam int TmrW   = $clog2(TmrMax + 1);
  localparam int DebW   = $clog2(DebounceCycles);

  typedef enum logic [1:0] {
    ST_ABSENT = 2'd0,
    ST_RESET  = 2'd1,
    ST_INIT   = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  logic [PortCount-1:0]    prs_s1_q, prs_s1_d, prs_s2_q, prs_s2_d;
  logic [PortCount-1:0]    int_s1_q, int_s1_d, int_s2_q, int_s2_d;
  logic [PortCount-1:0]    present_q, present_d;
  logic [PortCount-1:0]    pending_q, pending_d;
  logic                    irq_q, irq_d;
  logic [DebW-1:0]         deb_cnt_q [PortCount];
  logic [DebW-1:0]         deb_cnt_d [PortCount];
  logic [TmrW-1:0]         timer_q   [PortCount];
  logic [TmrW-1:0]         timer_d   [PortCount];
  logic [InsertCountW-1:0] ins_cnt_q [PortCount];
  logic [InsertCountW-1:0] ins_cnt_d [PortCount];
  state_e                  state_q   [PortCount];
  state_e                  state_d   [PortCount];

  always_ff @(posedge clock) begin
    if (!resetN) begin
      prs_s1_q  <= '1;
      prs_s2_q  <= '1;
      int_s1_q  <= '1;
      int_s2_q  <= '1;
      present_q <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      for (int p = 0; p < PortCount; p++) begin
        deb_cnt_q[p] <= '0;
        timer_q[p]   <= '0;
        ins_cnt_q[p] <= '0;
        state_q[p]   <= ST_ABSENT;
      end
    end else begin
      prs_s1_q  <= prs_s1_d;
      prs_s2_q  <= prs_s2_d;
      int_s1_q  <= int_s1_d;
      int_s2_q  <= int_s2_d;
      present_q <= present_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      for (int p = 0; p < PortCount; p++) begin
        deb_cnt_q[p] <= deb_cnt_d[p];
        timer_q[p]   <= timer_d[p];
        ins_cnt_q[p] <= ins_cnt_d[p];
        state_q[p]   <= state_d[p];
      end
    end
  end

  always_comb begin
    prs_s1_d  = modPrsL;
    prs_s2_d  = prs_s1_q;
    int_s1_d  = intL;
    int_s2_d  = int_s1_q;
    present_d = present_q;
    pending_d = pending_q;
    irq_d     = |(pending_q & ctlIntEnable);
    for (int p = 0; p < PortCount; p++) begin
      deb_cnt_d[p] = deb_cnt_q[p];
      timer_d[p]   = timer_q[p];
      ins_cnt_d[p] = ins_cnt_q[p];
      state_d[p]   = state_q[p];

      // s1 != s2 means the synced value changes on this edge, so the count restarts with it
      if (prs_s1_q[p] != prs_s2_q[p]) begin
        deb_cnt_d[p] = '0;
      end else if (deb_cnt_q[p] == DebW'(DebounceCycles - 1)) begin
        present_d[p] = ~prs_s2_q[p];
      end else begin
        deb_cnt_d[p] = deb_cnt_q[p] + DebW'(1);
      end

      // The FSM follows the presence value being registered this edge
      unique case (state_q[p])
        ST_ABSENT: begin
          if (present_d[p]) begin
            state_d[p] = ST_RESET;
            if (ins_cnt_q[p] != '1) ins_cnt_d[p] = ins_cnt_q[p] + InsertCountW'(1);
          end
        end
        ST_RESET: begin
          timer_d[p] = timer_q[p] + TmrW'(1);
          if (!present_d[p])                               state_d[p] = ST_ABSENT;
          else if (timer_q[p] == TmrW'(ResetCycles - 1))   state_d[p] = ST_INIT;
        end
        ST_INIT: begin
          timer_d[p] = timer_q[p] + TmrW'(1);
          if (!present_d[p])                               state_d[p] = ST_ABSENT;
          else if (ctlResetReq[p])                         state_d[p] = ST_RESET;
          else if (timer_q[p] == TmrW'(InitCycles - 1))    state_d[p] = ST_READY;
        end
        ST_READY: begin
          if (!present_d[p])                               state_d[p] = ST_ABSENT;
          else if (ctlResetReq[p])                         state_d[p] = ST_RESET;
        end
        default: state_d[p] = ST_ABSENT;
      endcase

      if (state_d[p] != state_q[p]) timer_d[p] = '0;

      if (ctlIntClear[p]) pending_d[p] = 1'b0;
      if (state_q[p] == ST_READY && !int_s2_q[p]) pending_d[p] = 1'b1;
    end
  end

  always_comb begin
    resetL      = '0;
    lpMode      = '1;
    modSelL     = '1;
    statState   = '0;
    insertCount = '0;
    for (int p = 0; p < PortCount; p++) begin
      resetL[p]                             = (state_q[p] == ST_INIT) || (state_q[p] == ST_READY);
      lpMode[p]                             = (state_q[p] == ST_READY) ? ctlLpMode[p] : 1'b1;
      modSelL[p]                            = (state_q[p] != ST_READY);
      statState[2*p +: 2]                   = state_q[p];
      insertCount[InsertCountW*p +: InsertCountW] = ins_cnt_q[p];
    end
  end

  assign statPresent = present_q;
  assign intPending  = pending_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_oc_qsfp_sideband.sv
// Directed bench for oc_qsfp_sideband: insertion sequencing, debounce, interrupts,
// reset requests, removal, insertion-count saturation and mid-sequence reset.
module tb_oc_qsfp_sideband;

  localparam int PortCount = 2;
  localparam int ICW       = 8;

  logic                       clock = 1'b0;
  logic                       resetN;
  logic [PortCount-1:0]       modPrsL, intL;
  logic [PortCount-1:0]       resetL, lpMode, modSelL;
  logic [PortCount-1:0]       ctlResetReq, ctlLpMode, ctlIntEnable, ctlIntClear;
  logic [2*PortCount-1:0]     statState;
  logic [PortCount-1:0]       statPresent, intPending;
  logic [ICW*PortCount-1:0]   insertCount;
  logic                       irq;

  int tests = 0;
  int fails = 0;

  oc_qsfp_sideband #(
    .PortCount(PortCount), .DebounceCycles(4), .ResetCycles(8),
    .InitCycles(16), .InsertCountW(ICW)
  ) dut (
    .clock(clock), .resetN(resetN), .modPrsL(modPrsL), .intL(intL),
    .resetL(resetL), .lpMode(lpMode), .modSelL(modSelL),
    .ctlResetReq(ctlResetReq), .ctlLpMode(ctlLpMode),
    .ctlIntEnable(ctlIntEnable), .ctlIntClear(ctlIntClear),
    .statState(statState), .statPresent(statPresent), .intPending(intPending),
    .insertCount(insertCount), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    modPrsL      = '1;
    intL         = '1;
    ctlResetReq  = '0;
    ctlLpMode    = '0;
    ctlIntEnable = '0;
    ctlIntClear  = '0;
    tick(2);
    resetN = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_resetL"},  32'(resetL),      32'h0);
    check({tag, "_lpMode"},  32'(lpMode),      32'h3);
    check({tag, "_modSelL"}, 32'(modSelL),     32'h3);
    check({tag, "_state"},   32'(statState),   32'h0);
    check({tag, "_present"}, 32'(statPresent), 32'h0);
    check({tag, "_pending"}, 32'(intPending),  32'h0);
    check({tag, "_inscnt"},  32'(insertCount), 32'h0);
    check({tag, "_irq"},     32'(irq),         32'h0);
  endtask

  task automatic insert_remove();
    modPrsL[0] = 1'b0;
    tick(8);
    modPrsL[0] = 1'b1;
    tick(8);
  endtask

  initial begin
    do_reset();
    check_reset_values("rst");

    // Insertion on port 0: present and RESET after 6 edges, INIT 8 later, READY 16 later
    modPrsL = 2'b10;
    tick(5);
    check("t1_present_early", 32'(statPresent[0]), 32'h0);
    check("t1_state_early",   32'(statState[1:0]), 32'h0);
    tick(1);
    check("t1_present",       32'(statPresent[0]), 32'h1);
    check("t1_state_reset",   32'(statState[1:0]), 32'h1);
    check("t1_resetL_low",    32'(resetL[0]),      32'h0);
    check("t1_inscnt",        32'(insertCount[7:0]), 32'h1);
    tick(7);
    check("t1_state_reset_end", 32'(statState[1:0]), 32'h1);
    check("t1_resetL_low_end",  32'(resetL[0]),      32'h0);
    tick(1);
    check("t1_state_init",    32'(statState[1:0]), 32'h2);
    check("t1_resetL_high",   32'(resetL[0]),      32'h1);
    check("t1_lpmode_init",   32'(lpMode[0]),      32'h1);
    check("t1_modsel_init",   32'(modSelL[0]),     32'h1);
    tick(15);
    check("t1_state_init_end", 32'(statState[1:0]), 32'h2);
    tick(1);
    check("t1_state_ready",   32'(statState[1:0]), 32'h3);
    check("t1_modsel_ready",  32'(modSelL[0]),     32'h0);
    check("t1_lpmode_ready0", 32'(lpMode[0]),      32'h0);
    ctlLpMode = 2'b11;
    #1;
    check("t1_lpmode_ready1", 32'(lpMode[0]),      32'h1);
    check("t1_lpmode_port1",  32'(lpMode[1]),      32'h1);
    ctlLpMode = 2'b00;
    check("t1_p1_state",      32'(statState[3:2]), 32'h0);
    check("t1_p1_present",    32'(statPresent[1]), 32'h0);
    check("t1_p1_inscnt",     32'(insertCount[15:8]), 32'h0);
    check("t1_p1_resetL",     32'(resetL[1]),      32'h0);

    // Interrupt latching: port 0 READY, port 1 ABSENT ignores its pin
    ctlIntEnable = 2'b11;
    intL = 2'b00;
    tick(2);
    check("t3_pending_sync",  32'(intPending),     32'h0);
    tick(1);
    check("t3_pending_set",   32'(intPending),     32'h1);
    check("t3_irq_lag",       32'(irq),            32'h0);
    tick(1);
    check("t3_irq_set",       32'(irq),            32'h1);
    ctlIntClear = 2'b01;
    tick(1);
    ctlIntClear = 2'b00;
    check("t3_set_wins",      32'(intPending),     32'h1);
    intL = 2'b11;
    tick(4);
    check("t3_sticky",        32'(intPending),     32'h1);
    ctlIntClear = 2'b01;
    tick(1);
    ctlIntClear = 2'b00;
    check("t3_cleared",       32'(intPending),     32'h0);
    tick(1);
    check("t3_irq_cleared",   32'(irq),            32'h0);
    intL = 2'b10;
    tick(3);
    check("t3_pending_again", 32'(intPending),     32'h1);
    tick(1);
    check("t3_irq_again",     32'(irq),            32'h1);
    ctlIntEnable = 2'b00;
    tick(1);
    check("t3_irq_masked",    32'(irq),            32'h0);
    ctlIntEnable = 2'b01;
    tick(1);
    check("t3_irq_unmasked",  32'(irq),            32'h1);

    // Mid-sequence reset with port 0 READY and interrupt pending
    check("t6_pre_state",     32'(statState[1:0]), 32'h3);
    resetN = 1'b0;
    tick(1);
    check_reset_values("t6");
    resetN = 1'b1;
    do_reset();

    // Debounce rejects a pin toggling every 3 cycles
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) modPrsL[0] = ~modPrsL[0];
      tick(1);
      check("t2_toggle", {30'h0, statPresent[0], statState[1:0] != 2'd0}, 32'h0);
    end
    tick(8);
    check("t2_settled_state",  32'(statState[1:0]),  32'h0);
    check("t2_settled_inscnt", 32'(insertCount[7:0]), 32'h0);

    // Reset request from INIT restarts RESET; a second request inside RESET is ignored
    do_reset();
    modPrsL = 2'b10;
    tick(14);
    check("t4_init_entry",    32'(statState[1:0]), 32'h2);
    tick(10);
    check("t4_init_t10",      32'(statState[1:0]), 32'h2);
    ctlResetReq = 2'b11;
    tick(1);
    ctlResetReq = 2'b00;
    check("t4_back_reset",    32'(statState[1:0]), 32'h1);
    check("t4_resetL_low",    32'(resetL[0]),      32'h0);
    check("t4_p1_ignored",    32'(statState[3:2]), 32'h0);
    tick(3);
    ctlResetReq = 2'b01;
    tick(1);
    ctlResetReq = 2'b00;
    check("t4_second_req",    32'(statState[1:0]), 32'h1);
    tick(3);
    check("t4_reset_last",    32'(statState[1:0]), 32'h1);
    check("t4_reset_last_rl", 32'(resetL[0]),      32'h0);
    tick(1);
    check("t4_init_again",    32'(statState[1:0]), 32'h2);
    check("t4_init_rl",       32'(resetL[0]),      32'h1);

    // Removal during RESET returns to ABSENT 6 cycles after the pin edge
    do_reset();
    modPrsL = 2'b10;
    tick(7);
    check("t5_in_reset",      32'(statState[1:0]), 32'h1);
    modPrsL = 2'b11;
    tick(5);
    check("t5_still_reset",   32'(statState[1:0]), 32'h1);
    check("t5_still_present", 32'(statPresent[0]), 32'h1);
    tick(1);
    check("t5_absent",        32'(statState[1:0]), 32'h0);
    check("t5_not_present",   32'(statPresent[0]), 32'h0);
    check("t5_lpmode",        32'(lpMode[0]),      32'h1);
    check("t5_modsel",        32'(modSelL[0]),     32'h1);
    check("t5_resetL",        32'(resetL[0]),      32'h0);
    check("t5_inscnt1",       32'(insertCount[7:0]), 32'h1);

    // Insertion counter counts then saturates
    do_reset();
    for (int i = 0; i < 10; i++) insert_remove();
    check("t5_inscnt10",      32'(insertCount[7:0]),  32'd10);
    for (int i = 0; i < 290; i++) insert_remove();
    check("t5_inscnt_sat",    32'(insertCount[7:0]),  32'd255);
    check("t5_p1_inscnt",     32'(insertCount[15:8]), 32'd0);
    check("t5_final_absent",  32'(statState[1:0]),    32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
